wb32to16_bridge: RTL and testbench



---
 rtl/wb_bridge_pkg.sv | 31 +++
 rtl/wb32to16_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_wb32to16_bridge.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the 32-to-16 bit Wishbone width adapter.
//   state_e      : bridge FSM states
//   HALF_HI/LO   : address bit [1] of the +0 / +2 halfword
//   sel_hi/sel_lo: byte-select pair for upstream bits [31:16] / [15:0]
//   lane_mask    : expands a 2-bit select into a 16-bit byte mask
package wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    GAP  = 3'd2,
    LO   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  function automatic logic [1:0] sel_hi(input logic [3:0] sel);
    return sel[3:2];
  endfunction

  function automatic logic [1:0] sel_lo(input logic [3:0] sel);
    return sel[1:0];
  endfunction

  function automatic logic [15:0] lane_mask(input logic [1:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb32to16_bridge.sv
// Wishbone width adapter: one 32-bit upstream access becomes zero, one or
// two 16-bit downstream accesses, steered by the byte selects. Read halves
// are reassembled and a single-cycle upstream ack is returned.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   wbs_*                  32-bit upstream slave side (adr, dat, sel, we, cyc, stb, ack)
//   wbm_*                  16-bit downstream master side
//
// Parameters:
//   BIG_ENDIAN  1: bits [31:16] live at +0, [15:0] at +2; 0: swapped
//   GAP_CYCLES  idle cycles (stb low, cyc held) between the two halves
//
// state | meaning
// IDLE  | waiting for upstream cyc & stb; request latched on acceptance
// HI    | downstream access for upstream bits [31:16]
// GAP   | stb low between halves so a registered stale ack is not consumed
// LO    | downstream access for upstream bits [15:0]
// DONE  | single-cycle upstream ack with reassembled read data
module wb32to16_bridge
  import wb_bridge_pkg::*;
#(
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i
);

  localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic UP_HALF = BIG_ENDIAN ? HALF_HI : HALF_LO;
  localparam logic DN_HALF = BIG_ENDIAN ? HALF_LO : HALF_HI;

  state_e           state_q, state_d;
  logic [29:0]      adr_q, adr_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      rd_q, rd_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [31:0] wbs_dat_q, wbs_dat_d;
  logic        wbs_ack_q, wbs_ack_d;
  logic [31:0] wbm_adr_q, wbm_adr_d;
  logic [15:0] wbm_dat_q, wbm_dat_d;
  logic [1:0]  wbm_sel_q, wbm_sel_d;
  logic        wbm_we_q, wbm_we_d;
  logic        wbm_cyc_q, wbm_cyc_d;
  logic        wbm_stb_q, wbm_stb_d;

  // Word-aligned access: the byte offset bits carry no information.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // Acks only count while our strobe is actually out on the bus.
  logic dn_ack;
  assign dn_ack = wbm_stb_q & wbm_ack_i;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rd_d      = rd_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d = wbs_adr_i[31:2];
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          dat_d = wbs_dat_i;
          rd_d  = '0;
          if (sel_hi(wbs_sel_i) != 2'b00)      state_d = HI;
          else if (sel_lo(wbs_sel_i) != 2'b00) state_d = LO;
          else                                 state_d = DONE;
        end
      end
      HI: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (dn_ack) begin
          if (!we_q) rd_d[31:16] = wbm_dat_i & lane_mask(sel_hi(sel_q));
          if (sel_lo(sel_q) == 2'b00) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d = LO;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (!wbs_cyc_i)             state_d = IDLE;
        else if (gap_cnt_q == '0)   state_d = LO;
        else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      LO: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (dn_ack) begin
          if (!we_q) rd_d[15:0] = wbm_dat_i & lane_mask(sel_lo(sel_q));
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    wbs_dat_d = '0;
    wbs_ack_d = 1'b0;
    wbm_adr_d = '0;
    wbm_dat_d = '0;
    wbm_sel_d = '0;
    wbm_we_d  = 1'b0;
    wbm_cyc_d = 1'b0;
    wbm_stb_d = 1'b0;

    case (state_d)
      HI: begin
        wbm_cyc_d = 1'b1;
        wbm_stb_d = 1'b1;
        wbm_we_d  = we_d;
        wbm_adr_d = {adr_d, UP_HALF, 1'b0};
        wbm_sel_d = sel_hi(sel_d);
        wbm_dat_d = dat_d[31:16];
      end
      GAP: begin
        wbm_cyc_d = 1'b1;
        wbm_we_d  = we_d;
      end
      LO: begin
        wbm_cyc_d = 1'b1;
        wbm_stb_d = 1'b1;
        wbm_we_d  = we_d;
        wbm_adr_d = {adr_d, DN_HALF, 1'b0};
        wbm_sel_d = sel_lo(sel_d);
        wbm_dat_d = dat_d[15:0];
      end
      DONE: begin
        wbs_ack_d = 1'b1;
        wbs_dat_d = rd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      rd_q      <= '0;
      gap_cnt_q <= '0;
      wbs_dat_q <= '0;
      wbs_ack_q <= 1'b0;
      wbm_adr_q <= '0;
      wbm_dat_q <= '0;
      wbm_sel_q <= '0;
      wbm_we_q  <= 1'b0;
      wbm_cyc_q <= 1'b0;
      wbm_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rd_q      <= rd_d;
      gap_cnt_q <= gap_cnt_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_ack_q <= wbs_ack_d;
      wbm_adr_q <= wbm_adr_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_sel_q <= wbm_sel_d;
      wbm_we_q  <= wbm_we_d;
      wbm_cyc_q <= wbm_cyc_d;
      wbm_stb_q <= wbm_stb_d;
    end
  end

  assign wbs_dat_o = wbs_dat_q;
  assign wbs_ack_o = wbs_ack_q;
  assign wbm_adr_o = wbm_adr_q;
  assign wbm_dat_o = wbm_dat_q;
  assign wbm_sel_o = wbm_sel_q;
  assign wbm_we_o  = wbm_we_q;
  assign wbm_cyc_o = wbm_cyc_q;
  assign wbm_stb_o = wbm_stb_q;

endmodule

// File: tb/tb_wb32to16_bridge.sv
// Bench for wb32to16_bridge: a 16-bit RAM slave with registered ack and
// registered read data, a queue of expected downstream accesses built from
// the byte-select rules, and a per-cycle compare process.
module tb_wb32to16_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o;
  logic [31:0] wbm_adr_o;
  logic [15:0] wbm_dat_o, wbm_dat_i;
  logic [1:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

  always #5 clk_i = ~clk_i;

  wb32to16_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycnt   = 0;
  always @(posedge clk_i) cycnt <= cycnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- 16-bit RAM slave ----------------
  logic [15:0] mem [int];
  logic        ack_r = 1'b0;
  logic        extra_ack = 1'b0;
  logic [15:0] rdata_r = 16'h0;
  int          wcnt = 0;
  int          slv_acks = 0;
  int          delay_val = 0;
  int          delay_idx = -1;

  assign wbm_ack_i = ack_r | extra_ack;
  assign wbm_dat_i = rdata_r;

  function automatic logic [15:0] rd16(input int a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  always @(posedge clk_i) begin
    int a;
    logic [15:0] old;
    ack_r <= 1'b0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wcnt >= ((slv_acks == delay_idx) ? delay_val : 0)) begin
        a = int'(wbm_adr_o);
        old = rd16(a);
        ack_r    <= 1'b1;
        wcnt     <= 0;
        slv_acks <= slv_acks + 1;
        rdata_r  <= old;
        if (wbm_we_o)
          mem[a] = {wbm_sel_o[1] ? wbm_dat_o[15:8] : old[15:8],
                    wbm_sel_o[0] ? wbm_dat_o[7:0]  : old[7:0]};
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- model ----------------
  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] exp_rd;
  bit          mon_en = 1'b0;
  int          t0 = 0;
  logic [31:0] stb_hist, cyc_hist, rd_seen;

  function automatic logic [15:0] mask16(input logic [1:0] s);
    return (s[1] ? 16'hFF00 : 16'h0000) | (s[0] ? 16'h00FF : 16'h0000);
  endfunction

  task automatic start_req(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
    logic [31:0] base;
    base = {adr[31:2], 2'b00};
    exp_q.delete();
    if (sel[3:2] != 2'b00) exp_q.push_back('{base,     dat[31:16], sel[3:2], we});
    if (sel[1:0] != 2'b00) exp_q.push_back('{base + 2, dat[15:0],  sel[1:0], we});
    exp_rd = we ? 32'h0 : {rd16(int'(base)) & mask16(sel[3:2]),
                           rd16(int'(base + 2)) & mask16(sel[1:0])};
    @(posedge clk_i); #1;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    t0 = cycnt;
  endtask

  task automatic wait_ack(input string nm, output int ack_cyc);
    int c;
    stb_hist = '0; cyc_hist = '0; rd_seen = '0; ack_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      c = cycnt - t0;
      if (c >= 0 && c < 32) begin
        if (wbm_stb_o) stb_hist[c] = 1'b1;
        if (wbm_cyc_o) cyc_hist[c] = 1'b1;
      end
      if (wbs_ack_o) begin
        ack_cyc = c;
        rd_seen = wbs_dat_o;
        break;
      end
    end
    if (ack_cyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no wbs_ack_o within 40 cycles", nm);
    end
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk_i);
    chk({nm, "_ack_single"}, 32'(wbs_ack_o), 32'h0);
  endtask

  // Per-cycle compare against the expected access queue.
  always @(negedge clk_i) begin
    if (rst_i && mon_en) begin
      if (wbm_stb_o) begin
        chk("stb_implies_cyc", 32'(wbm_cyc_o), 32'h1);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_access: adr %h, none expected", wbm_adr_o);
        end else begin
          chk("wbm_adr", wbm_adr_o, exp_q[0].adr);
          chk("wbm_sel", 32'(wbm_sel_o), 32'(exp_q[0].sel));
          chk("wbm_we", 32'(wbm_we_o), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("wbm_dat", 32'(wbm_dat_o), 32'(exp_q[0].dat));
          if (wbm_ack_i) void'(exp_q.pop_front());
        end
      end
      if (wbs_ack_o) begin
        chk("wbs_dat", wbs_dat_o, exp_rd);
        chk("halves_done", 32'(exp_q.size()), 32'h0);
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_wbs_dat"}, wbs_dat_o, 32'h0);
    chk({nm, "_wbm_adr"}, wbm_adr_o, 32'h0);
    chk({nm, "_ctl"}, 32'({wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbs_ack_o}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    bit found;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset");
    @(posedge clk_i); #1 rst_i = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk_i);

    // 1: full write, two halves with a gap
    start_req(32'h100, 32'h12345678, 4'b1111, 1'b1);
    wait_ack("t1", ac);
    chk("t1_ack_cyc", 32'(ac), 32'd6);
    chk("t1_stb_hist", stb_hist, 32'h36);
    chk("t1_cyc_hist", cyc_hist, 32'h3E);
    chk("t1_mem100", 32'(rd16(32'h100)), 32'h1234);
    chk("t1_mem102", 32'(rd16(32'h102)), 32'h5678);

    // 2: full read, stale ack in the gap must not advance
    mem[32'h100] = 16'hCAFE; mem[32'h102] = 16'hBEEF;
    start_req(32'h100, 32'h0, 4'b1111, 1'b0);
    wait_ack("t2", ac);
    chk("t2_ack_cyc", 32'(ac), 32'd6);
    chk("t2_rd", rd_seen, 32'hCAFEBEEF);
    chk("t2_stb_hist", stb_hist, 32'h36);

    // 3: single-half writes
    start_req(32'h204, 32'hAAAA5555, 4'b0011, 1'b1);
    wait_ack("t3a", ac);
    chk("t3a_ack_cyc", 32'(ac), 32'd3);
    chk("t3a_stb_hist", stb_hist, 32'h06);
    chk("t3a_mem206", 32'(rd16(32'h206)), 32'h5555);
    start_req(32'h204, 32'hAAAA5555, 4'b1100, 1'b1);
    wait_ack("t3b", ac);
    chk("t3b_ack_cyc", 32'(ac), 32'd3);
    chk("t3b_mem204", 32'(rd16(32'h204)), 32'hAAAA);

    // 4: partial reads and the empty select
    mem[32'h300] = 16'h5A3C; mem[32'h302] = 16'h1357;
    start_req(32'h300, 32'h0, 4'b0100, 1'b0);
    wait_ack("t4a", ac);
    chk("t4a_ack_cyc", 32'(ac), 32'd3);
    chk("t4a_rd", rd_seen, 32'h003C0000);
    start_req(32'h300, 32'h0, 4'b0000, 1'b0);
    wait_ack("t4b", ac);
    chk("t4b_ack_cyc", 32'(ac), 32'd1);
    chk("t4b_cyc_hist", cyc_hist, 32'h0);
    start_req(32'h300, 32'h0, 4'b1001, 1'b0);
    wait_ack("t4c", ac);
    chk("t4c_ack_cyc", 32'(ac), 32'd6);
    chk("t4c_rd", rd_seen, 32'h5A000057);

    // 5: spurious acks while idle, then a 5-cycle delayed first half
    @(posedge clk_i); #1 extra_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("t5_idle_noack", 32'({wbs_ack_o, wbm_cyc_o}), 32'h0);
    end
    @(posedge clk_i); #1 extra_ack = 1'b0;
    delay_val = 5; delay_idx = slv_acks;
    start_req(32'h100, 32'h0, 4'b1111, 1'b0);
    wait_ack("t5", ac);
    delay_idx = -1;
    chk("t5_ack_cyc", 32'(ac), 32'd11);
    chk("t5_rd", rd_seen, 32'hCAFEBEEF);
    chk("t5_stb_hist", stb_hist, 32'h6FE);

    // 6a: reset while in the gap
    start_req(32'h400, 32'h11112222, 4'b1111, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (wbm_cyc_o && !wbm_stb_o) found = 1'b1;
    end
    chk("t6a_gap_seen", 32'(found), 32'h1);
    mon_en = 1'b0;
    rst_i = 1'b0;
    #1;
    chk_all_zero("t6a_rst");
    exp_q.delete();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("t6a_quiet", 32'({wbs_ack_o, wbm_cyc_o}), 32'h0);
    end
    mon_en = 1'b1;
    start_req(32'h500, 32'hDEADBEEF, 4'b1111, 1'b1);
    wait_ack("t6a_next", ac);
    chk("t6a_next_ack_cyc", 32'(ac), 32'd6);
    chk("t6a_mem502", 32'(rd16(32'h502)), 32'hBEEF);

    // 6b: upstream abort during the low half
    start_req(32'h100, 32'h0, 4'b1111, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (wbm_stb_o && wbm_adr_o[1]) found = 1'b1;
    end
    chk("t6b_lo_seen", 32'(found), 32'h1);
    mon_en = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("t6b_abort");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t6b_quiet", 32'({wbs_ack_o, wbm_cyc_o}), 32'h0);
    end
    exp_q.delete();
    mon_en = 1'b1;
    start_req(32'h100, 32'h0, 4'b1111, 1'b0);
    wait_ack("t6b_next", ac);
    chk("t6b_next_ack_cyc", 32'(ac), 32'd6);
    chk("t6b_next_rd", rd_seen, 32'hCAFEBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
